// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide, one step per cycle, signed ops run on magnitudes with sign fix-up.
module riscv_muldiv_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              flush,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [TAG_W-1:0]  tag_in,
   output logic              busy,
   output logic              valid,
   output logic [DATA_W-1:0] result,
   output logic [TAG_W-1:0]  tag_out
);

   localparam int unsigned CW = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] MIN_INT = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] ONES    = {DATA_W{1'b1}};
   localparam logic [CW-1:0]     CNT_TOP = CW'(DATA_W-1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

   state_e            state_q;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        fn_q;
   logic              neg_q;
   logic [DATA_W-1:0] hi_q, lo_q, b_q;
   logic [TAG_W-1:0]  tag_q, tag_out_q;
   logic [DATA_W-1:0] result_q;
   logic              busy_q, valid_q;

   logic              a_sgn, b_sgn, a_neg, b_neg, neg_d;
   logic [DATA_W-1:0] a_mag, b_mag;
   logic              div0, ovf;
   logic [DATA_W-1:0] spec_res;

   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_r;
   logic                div_ge;
   logic [DATA_W-1:0]   hi_d, lo_d;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   quo, rem, res_fin;

   // Operand conditioning at accept time
   always_comb begin
      a_sgn = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]);
      b_sgn = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
      a_neg = a_sgn & op_a[DATA_W-1];
      b_neg = b_sgn & op_b[DATA_W-1];
      a_mag = a_neg ? -op_a : op_a;
      b_mag = b_neg ? -op_b : op_b;
      neg_d = (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
      div0  = funct3[2] & (op_b == '0);
      ovf   = funct3[2] & ~funct3[0] & (op_a == MIN_INT) & (op_b == ONES);
      if (div0) spec_res = funct3[1] ? op_a : ONES;
      else      spec_res = funct3[1] ? '0 : MIN_INT;
   end

   // One iteration step plus final sign fix-up
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_r   = {hi_q, lo_q[DATA_W-1]};
      div_ge  = div_r[DATA_W] | (div_r[DATA_W-1:0] >= b_q);
      if (fn_q[2]) begin
         hi_d = div_ge ? (div_r[DATA_W-1:0] - b_q) : div_r[DATA_W-1:0];
         lo_d = {lo_q[DATA_W-2:0], div_ge};
      end else begin
         hi_d = mul_sum[DATA_W:1];
         lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
      end
      prod = {hi_d, lo_d};
      if (neg_q) prod = -prod;
      quo = neg_q ? -lo_d : lo_d;
      rem = neg_q ? -hi_d : hi_d;
      case (fn_q)
         3'b000:                 res_fin = prod[DATA_W-1:0];
         3'b001, 3'b010, 3'b011: res_fin = prod[2*DATA_W-1:DATA_W];
         3'b100, 3'b101:         res_fin = quo;
         default:                res_fin = rem;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         fn_q      <= '0;
         neg_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         b_q       <= '0;
         tag_q     <= '0;
         tag_out_q <= '0;
         result_q  <= '0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else if (flush) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_CALC: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  result_q  <= res_fin;
                  tag_out_q <= tag_q;
                  state_q   <= S_DONE;
                  busy_q    <= 1'b0;
                  valid_q   <= 1'b1;
               end
            end
            default: begin
               if (start) begin
                  fn_q  <= funct3;
                  neg_q <= neg_d;
                  hi_q  <= '0;
                  lo_q  <= a_mag;
                  b_q   <= b_mag;
                  tag_q <= tag_in;
                  cnt_q <= CNT_TOP;
                  if (div0 | ovf) begin
                     result_q  <= spec_res;
                     tag_out_q <= tag_in;
                     state_q   <= S_DONE;
                     busy_q    <= 1'b0;
                     valid_q   <= 1'b1;
                  end else begin
                     state_q <= S_CALC;
                     busy_q  <= 1'b1;
                     valid_q <= 1'b0;
                  end
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign valid   = valid_q;
   assign result  = result_q;
   assign tag_out = tag_out_q;

endmodule
